// File: rtl/mux4x1_lane_sched_pkg.sv
// Shared widths, lane/byte types and the round-robin lane search used by the
// four-lane byte scheduler.
package mux4x1_lane_sched_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [LANE_W-1:0] lane_t;

  localparam byte_t IDLE_BYTE_DEF = 8'h00;

  typedef struct packed {
    logic  found;
    lane_t lane;
  } pick_t;

  // First lane with data, starting at ptr and wrapping modulo LANES.
  function automatic pick_t rr_pick(input logic [LANES-1:0] nonempty, input lane_t ptr);
    pick_t p;
    lane_t c;
    p = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      c = ptr + lane_t'(k);
      if (!p.found && nonempty[c]) begin
        p.found = 1'b1;
        p.lane  = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4x1_lane_sched_if.sv
// Lane push handshake and merged output stream of the four-lane scheduler.
interface mux4x1_lane_sched_if;
  import mux4x1_lane_sched_pkg::*;

  byte_t             in0, in1, in2, in3;
  logic [LANES-1:0]  valid;
  logic [LANES-1:0]  ready;
  logic              out_ready;
  byte_t             out;
  logic              out_valid;
  lane_t             out_lane;
  logic [LANES-1:0]  lane_full;

  modport master (
    output in0, in1, in2, in3, valid, out_ready,
    input  ready, out, out_valid, out_lane, lane_full
  );

  modport slave (
    input  in0, in1, in2, in3, valid, out_ready,
    output ready, out, out_valid, out_lane, lane_full
  );

endinterface

// File: rtl/mux4x1_lane_sched_lane_fifo.sv
// Per-lane synchronous FIFO; push is refused when full, pop when empty.
module lane_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // No bypass: a full FIFO refuses the push even when it pops the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mux4x1_lane_sched.sv
// Round-robin scheduler merging four lane FIFOs onto one registered byte
// stream tagged with its source lane, with downstream backpressure.
module mux4x1_lane_sched
  import mux4x1_lane_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter byte_t       IDLE_BYTE = IDLE_BYTE_DEF
) (
  input logic              clk,
  input logic              reset,
  mux4x1_lane_sched_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  byte_t            lane_data [LANES];
  byte_t            head      [LANES];
  logic [CW-1:0]    count     [LANES];
  logic [LANES-1:0] full, empty, pop, ready;
  lane_t            ptr;
  pick_t            pick;
  logic             advance;

  assign lane_data[0] = bus.in0;
  assign lane_data[1] = bus.in1;
  assign lane_data[2] = bus.in2;
  assign lane_data[3] = bus.in3;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ready[i] = ~reset & (count[i] < CW'(DEPTH));

    lane_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.valid[i] & ready[i]),
      .din   (lane_data[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign bus.ready     = ready;
  assign bus.lane_full = full;

  always_comb begin
    pop     = '0;
    advance = ~bus.out_valid | bus.out_ready;
    pick    = rr_pick(~empty, ptr);
    if (advance && pick.found)
      pop[pick.lane] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out       <= IDLE_BYTE;
      bus.out_valid <= 1'b0;
      bus.out_lane  <= '0;
      ptr           <= '0;
    end else if (advance) begin
      if (pick.found) begin
        bus.out       <= head[pick.lane];
        bus.out_lane  <= pick.lane;
        bus.out_valid <= 1'b1;
        ptr           <= pick.lane + lane_t'(1);
      end else begin
        bus.out       <= IDLE_BYTE;
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
